// File: rtl/sad_popcount.sv
// Chunked popcount of a SAD XOR difference vector with per-frame minimum tracking.
// One vector is accepted in IDLE, scored over DATA_W/CHUNK_W cycles, and reported in DONE.
module sad_popcount #(
    parameter int DATA_W  = 4000,
    parameter int CHUNK_W = 250,
    parameter int POS_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [DATA_W-1:0] d_in,
    input  logic              in_valid,
    input  logic              frame_start,
    output logic              in_ready,
    output logic [11:0]       score,
    output logic              score_valid,
    output logic [11:0]       best_score,
    output logic [POS_W-1:0]  best_pos
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state_r;
    logic [DATA_W-1:0] d_r;
    logic              fs_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [11:0]       acc_r;
    logic [11:0]       score_r;
    logic              score_valid_r;
    logic [11:0]       best_score_r;
    logic [POS_W-1:0]  best_pos_r;
    logic [POS_W-1:0]  pos_r;

    logic [11:0]       chunk_pop_s;
    logic [POS_W-1:0]  pos_cur_s;
    logic              last_chunk_s;

    function automatic logic [11:0] popcount(input logic [CHUNK_W-1:0] v);
        logic [11:0] c;
        c = 12'd0;
        for (int i = 0; i < CHUNK_W; i++) begin
            c = c + {11'd0, v[i]};
        end
        return c;
    endfunction

    // Popcount of the low chunk; the latched vector shifts down one chunk per ACCUM cycle.
    always_comb begin
        chunk_pop_s  = popcount(d_r[CHUNK_W-1:0]);
        last_chunk_s = (cnt_r == CNT_W'(NCHUNK - 1));
        if (fs_r) begin
            pos_cur_s = {POS_W{1'b0}};
        end else begin
            pos_cur_s = pos_r + POS_W'(1);
        end
    end

    // Main FSM, accumulator, score and best-window tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            d_r           <= {DATA_W{1'b0}};
            fs_r          <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
            acc_r         <= 12'd0;
            score_r       <= 12'd0;
            score_valid_r <= 1'b0;
            best_score_r  <= 12'hFFF;
            best_pos_r    <= {POS_W{1'b0}};
            pos_r         <= {POS_W{1'b0}};
        end else if (!ena) begin
            score_valid_r <= 1'b0;
        end else begin
            score_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        d_r     <= d_in;
                        fs_r    <= frame_start;
                        acc_r   <= 12'd0;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ACCUM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCUM: begin
                    acc_r <= acc_r + chunk_pop_s;
                    d_r   <= d_r >> CHUNK_W;
                    if (last_chunk_s) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    score_r       <= acc_r;
                    score_valid_r <= 1'b1;
                    pos_r         <= pos_cur_s;
                    // Strict compare: ties keep the earlier window.
                    if (fs_r) begin
                        best_score_r <= acc_r;
                        best_pos_r   <= {POS_W{1'b0}};
                    end else if (acc_r < best_score_r) begin
                        best_score_r <= acc_r;
                        best_pos_r   <= pos_cur_s;
                    end else begin
                        best_score_r <= best_score_r;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_r == IDLE) && ena;
    assign score       = score_r;
    assign score_valid = score_valid_r;
    assign best_score  = best_score_r;
    assign best_pos    = best_pos_r;

endmodule

// File: doc/sad_popcount.md
SAD_POPCOUNT -- requirements
Module: sad_popcount

Interface
REQ-001 Parameter DATA_W, default 4000, width of XOR difference vector.
REQ-002 Parameter CHUNK_W, default 250, bits popcounted per cycle; DATA_W SHALL be a multiple of CHUNK_W.
REQ-003 Parameter POS_W, default 16, width of window position counter.
REQ-004 Clock and reset: clk, one clock; reset is synchronous and active-high (rst).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 ena  input  1  global enable; low freezes all state and outputs.
REQ-008 d_in  input  DATA_W  XOR difference vector from the SAD stage.
REQ-009 in_valid  input  1  d_in holds a new window.
REQ-010 frame_start  input  1  qualifies accepted vector as first window of a frame.
REQ-011 in_ready  output  1  block can accept a vector this cycle.
REQ-012 score  output  12  Hamming weight of last completed vector.
REQ-013 score_valid  output  1  one-cycle pulse, score updated.
REQ-014 best_score  output  12  minimum score since last frame_start.
REQ-015 best_pos  output  POS_W  window index of best_score.

Function
REQ-016 FSM states: IDLE, ACCUM, DONE; all transitions only when ena=1.
REQ-017 in_ready SHALL be 1 only in IDLE with ena=1; transfer occurs when in_valid and in_ready are both 1.
REQ-018 On transfer: latch d_in into an internal register, latch frame_start, clear accumulator and chunk counter, go to ACCUM.
REQ-019 ACCUM: each cycle add popcount of chunk[cnt] (bits cnt*CHUNK_W .. cnt*CHUNK_W+CHUNK_W-1) to 12-bit accumulator; cnt increments 0..DATA_W/CHUNK_W-1; after the last chunk go to DONE.
REQ-020 Accumulator SHALL never overflow: max value DATA_W (4000) fits 12 bits.
REQ-021 DONE: score <= accumulator, score_valid=1 for exactly that cycle, update best, advance position, return to IDLE.
REQ-022 Latency: transfer at cycle T gives score_valid at T+DATA_W/CHUNK_W+1 (T+17 at defaults); throughput one vector per 18 cycles.
REQ-023 Position counter: frame_start vector gets position 0; every other vector gets previous position+1, wrapping from 2^POS_W-1 to 0.
REQ-024 Best update: if latched frame_start=1, best_score<=score, best_pos<=0; else if score < best_score (strict), best_score<=score, best_pos<=position; ties keep earlier position.
REQ-025 ena=0 mid-ACCUM: cnt, accumulator and state hold; resume unchanged on ena=1; score_valid held 0 while ena=0.
REQ-026 in_valid while not in IDLE SHALL be ignored; no buffering; upstream holds data until in_ready.
REQ-027 d_in changes after transfer SHALL NOT affect the score in progress.

Reset
REQ-028 rst=1 at a clock edge, regardless of ena or state: state=IDLE, cnt=0, accumulator=0, score=0, score_valid=0, best_score=12'hFFF, best_pos=0, position counter=0.
REQ-029 Reset mid-ACCUM SHALL abort the vector with no score_valid pulse; in_ready=1 the first cycle after rst deasserts with ena=1.

Verification
REQ-030 All-zero d_in, frame_start=1 -> score=0, best_score=0, best_pos=0, score_valid 17 cycles after transfer.
REQ-031 All-ones d_in -> score=4000; single bit set in chunk 15 (bit 3999) -> score=1.
REQ-032 Frame of scores 10,5,5,7 (first with frame_start) -> best_score=5, best_pos=1.
REQ-033 ena low for 5 cycles during ACCUM -> score_valid delayed exactly 5 cycles, score unchanged.
REQ-034 rst asserted at chunk 8 -> no score_valid, best_score=4095, next vector scored correctly.
REQ-035 65537 windows with single frame_start -> last window position 0; in_valid during ACCUM never accepted.
